// File: rtl/hazard_pkg.sv
// Shared types for the ID-stage hazard controller: FSM states, pipeline control bundle,
// and the branch/load-use priority resolution used by both RUN and the MEM_WAIT exit cycle.
package hazard_pkg;

  typedef enum logic [1:0] {BOOT, RUN, MEM_WAIT, ERROR} hazard_state_t;

  typedef struct packed {
    logic stall_pc;
    logic stall_id;
    logic flush_id;
    logic bubble_ex;
    logic freeze;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t NOP_CTRL  = '0;
  localparam pipe_ctrl_t BOOT_CTRL = '{stall_pc: 1'b1, stall_id: 1'b0, flush_id: 1'b1,
                                       bubble_ex: 1'b1, freeze: 1'b0};

  // A taken branch squashes the ID instruction, so a load-use stall on it is moot.
  function automatic pipe_ctrl_t run_ctrl(input logic taken, input logic load_use);
    pipe_ctrl_t c;
    c = NOP_CTRL;
    if (taken) begin
      c.flush_id  = 1'b1;
      c.bubble_ex = 1'b1;
    end else if (load_use) begin
      c.stall_pc  = 1'b1;
      c.stall_id  = 1'b1;
      c.bubble_ex = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Decoded pipeline traits in, stall/flush/freeze controls out.
// HAZARD_PERF_EN adds the stall_cycles / flush_count counter outputs.
interface hazard_controller_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             ex_is_lw;
  logic [REG_W-1:0] ex_rt;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             stall_pc;
  logic             stall_id;
  logic             flush_id;
  logic             bubble_ex;
  logic             freeze;
  logic             mem_timeout;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
`endif

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_is_lw, ex_rt, ex_branch_taken, mem_req, mem_ready,
`ifdef HAZARD_PERF_EN
    input  stall_cycles, flush_count,
`endif
    input  stall_pc, stall_id, flush_id, bubble_ex, freeze, mem_timeout
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_is_lw, ex_rt, ex_branch_taken, mem_req, mem_ready,
`ifdef HAZARD_PERF_EN
    output stall_cycles, flush_count,
`endif
    output stall_pc, stall_id, flush_id, bubble_ex, freeze, mem_timeout
  );
endinterface

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of the LW currently in EX.
module load_use_detect #(
  parameter int REG_W = 5
) (
  input  logic             ex_is_lw,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             hazard
);
  // $zero never carries a dependency.
  assign hazard = ex_is_lw && (ex_rt != '0) &&
                  ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencer: boot hold, branch flush, load-use stall, data-memory wait + watchdog.
// Optional HAZARD_PERF_EN adds saturating stall/flush cycle counters.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int REG_W       = 5,
  parameter int RESET_HOLD  = 2,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input logic               clk,
  input logic               reset,
  hazard_controller_if.slave hz
);
  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  hazard_state_t     state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  pipe_ctrl_t        ctrl;
  logic              load_use;
  logic              mem_pending;

  load_use_detect #(.REG_W(REG_W)) u_lud (
    .ex_is_lw   (hz.ex_is_lw),
    .ex_rt      (hz.ex_rt),
    .id_rs      (hz.id_rs),
    .id_rt      (hz.id_rt),
    .id_uses_rt (hz.id_uses_rt),
    .hazard     (load_use)
  );

  // Once waiting, only mem_ready matters; mem_ready alone in RUN is ignored.
  assign mem_pending = (state_q == MEM_WAIT) ? !hz.mem_ready : (hz.mem_req && !hz.mem_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      hold_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    wait_d  = wait_q;
    case (state_q)
      BOOT: begin
        hold_d = hold_q + HOLD_W'(1);
        if (hold_q == HOLD_W'(RESET_HOLD - 1)) begin
          state_d = RUN;
          hold_d  = '0;
        end
      end
      RUN: begin
        if (mem_pending) begin
          wait_d  = WAIT_W'(1);
          state_d = (MEM_TIMEOUT == 1) ? ERROR : MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (!mem_pending) begin
          state_d = RUN;
          wait_d  = '0;
        end else begin
          if (wait_q != '1) wait_d = wait_q + WAIT_W'(1);
          // Trip on the cycle that completes MEM_TIMEOUT consecutive wait cycles.
          if (MEM_TIMEOUT != 0 && wait_d == WAIT_W'(MEM_TIMEOUT)) state_d = ERROR;
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    ctrl           = NOP_CTRL;
    hz.mem_timeout = 1'b0;
    case (state_q)
      BOOT: ctrl = BOOT_CTRL;
      RUN, MEM_WAIT: begin
        if (mem_pending) ctrl.freeze = 1'b1;
        else             ctrl = run_ctrl(hz.ex_branch_taken, load_use);
      end
      ERROR: begin
        ctrl.freeze    = 1'b1;
        hz.mem_timeout = 1'b1;
      end
      default: ctrl = BOOT_CTRL;
    endcase
  end

  assign hz.stall_pc  = ctrl.stall_pc;
  assign hz.stall_id  = ctrl.stall_id;
  assign hz.flush_id  = ctrl.flush_id;
  assign hz.bubble_ex = ctrl.bubble_ex;
  assign hz.freeze    = ctrl.freeze;

`ifdef HAZARD_PERF_EN
  logic             perf_active;
  logic [CNT_W-1:0] stall_q, flush_q;

  assign perf_active = (state_q == RUN) || (state_q == MEM_WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else if (perf_active) begin
      if ((ctrl.stall_pc || ctrl.freeze) && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
      if (ctrl.flush_id && flush_q != '1)                  flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign hz.stall_cycles = stall_q;
  assign hz.flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed + randomized check of hazard_controller against a cycle-count reference model.
module tb_hazard_controller;
  localparam int REG_W       = 5;
  localparam int RESET_HOLD  = 2;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 3;
  localparam int SAT         = (1 << CNT_W) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hazard_controller_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hz ();

  hazard_controller #(
    .REG_W(REG_W), .RESET_HOLD(RESET_HOLD), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: boot cycles left, consecutive memory wait cycles, sticky error.
  int boot_left;
  int wait_cycles;
  bit err;
  int m_stall;
  int m_flush;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] observed();
    return {hz.stall_pc, hz.stall_id, hz.flush_id, hz.bubble_ex, hz.freeze, hz.mem_timeout};
  endfunction

  // Bit order: {stall_pc, stall_id, flush_id, bubble_ex, freeze, mem_timeout}
  function automatic logic [5:0] expect_out();
    bit pending, lu;
    if (boot_left > 0) return 6'b101100;
    if (err)           return 6'b000011;
    pending = (wait_cycles > 0) ? !hz.mem_ready : (hz.mem_req && !hz.mem_ready);
    if (pending)            return 6'b000010;
    if (hz.ex_branch_taken) return 6'b001100;
    lu = hz.ex_is_lw && hz.ex_rt != 0 &&
         (hz.ex_rt == hz.id_rs || (hz.id_uses_rt && hz.ex_rt == hz.id_rt));
    return lu ? 6'b110100 : 6'b000000;
  endfunction

  task automatic model_reset();
    boot_left = RESET_HOLD; wait_cycles = 0; err = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic check_perf(input string tag);
`ifdef HAZARD_PERF_EN
    check({tag, "_stallcnt"}, 32'(hz.stall_cycles), 32'(m_stall));
    check({tag, "_flushcnt"}, 32'(hz.flush_count),  32'(m_flush));
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  task automatic step(input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                      input logic urt, input logic lw, input logic [REG_W-1:0] ert,
                      input logic tk, input logic mreq, input logic mrdy,
                      input string tag, output logic [5:0] obs);
    logic [5:0] e;
    @(negedge clk);
    hz.id_rs = rs; hz.id_rt = rt; hz.id_uses_rt = urt; hz.ex_is_lw = lw; hz.ex_rt = ert;
    hz.ex_branch_taken = tk; hz.mem_req = mreq; hz.mem_ready = mrdy;
    #2;
    e   = expect_out();
    obs = observed();
    check(tag, 32'(obs), 32'(e));
    check_perf(tag);
    if (boot_left > 0) boot_left--;
    else if (!err) begin
      if (e[5] || e[1]) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
      if (e[3])         m_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
      if (e[1]) begin
        wait_cycles++;
        if (wait_cycles == MEM_TIMEOUT) err = 1;
      end else wait_cycles = 0;
    end
  endtask

  task automatic idle(input string tag, output logic [5:0] obs);
    step(0, 0, 0, 0, 0, 0, 0, 0, tag, obs);
  endtask

  // Reset raised between clock edges must take effect immediately.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check(tag, 32'(observed()), 32'(6'b101100));
    check_perf(tag);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [5:0] o;
    hz.id_rs = 0; hz.id_rt = 0; hz.id_uses_rt = 0; hz.ex_is_lw = 0; hz.ex_rt = 0;
    hz.ex_branch_taken = 0; hz.mem_req = 0; hz.mem_ready = 0;
    model_reset();

    // Reset state and boot hold
    @(negedge clk); #2;
    check("in_reset", 32'(observed()), 32'(6'b101100));
    check_perf("in_reset");
    @(posedge clk); #1 reset = 1'b0;
    step(8, 8, 1, 1, 8, 1, 1, 0, "boot0", o); check("boot0_const", 32'(o), 32'(6'b101100));
    step(8, 8, 1, 1, 8, 1, 1, 0, "boot1", o); check("boot1_const", 32'(o), 32'(6'b101100));
    idle("run0", o);                          check("run0_const",  32'(o), 32'(6'b000000));

    // Load-use and its exceptions
    step(8, 0, 0, 1, 8, 0, 0, 0, "lu_rs", o);     check("lu_rs_const", 32'(o), 32'(6'b110100));
    idle("lu_after", o);                          check("lu_after_const", 32'(o), 32'(6'b000000));
    step(0, 0, 1, 1, 0, 0, 0, 0, "lu_zero", o);   check("lu_zero_const", 32'(o), 32'(6'b000000));
    step(1, 8, 0, 1, 8, 0, 0, 0, "lu_nort", o);   check("lu_nort_const", 32'(o), 32'(6'b000000));
    step(1, 8, 1, 1, 8, 0, 0, 0, "lu_rt", o);     check("lu_rt_const", 32'(o), 32'(6'b110100));

    // Branch overrides load-use
    step(2, 9, 1, 1, 9, 1, 0, 0, "br_over_lu", o); check("br_const", 32'(o), 32'(6'b001100));

    // Memory wait of three cycles, exit cycle evaluates load-use
    for (int i = 0; i < 3; i++) begin
      step(8, 0, 0, 1, 8, 0, 1, 0, "mw_wait", o);  check("mw_wait_const", 32'(o), 32'(6'b000010));
    end
    step(8, 0, 0, 1, 8, 0, 1, 1, "mw_exit", o);    check("mw_exit_const", 32'(o), 32'(6'b110100));
    idle("mw_run", o);                             check("mw_run_const", 32'(o), 32'(6'b000000));
    step(0, 0, 0, 0, 0, 0, 0, 1, "rdy_noreq", o);  check("rdy_noreq_const", 32'(o), 32'(6'b000000));

    // Watchdog: four wait cycles then sticky error until reset
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1, 0, "wd_wait", o);
    step(0, 0, 0, 0, 0, 1, 1, 1, "wd_err0", o);    check("wd_err0_const", 32'(o), 32'(6'b000011));
    step(3, 3, 1, 1, 3, 0, 0, 1, "wd_err1", o);    check("wd_err1_const", 32'(o), 32'(6'b000011));
    async_reset("wd_reset");
    idle("wd_boot0", o);
    idle("wd_boot1", o);

    // Reset in the middle of a memory wait
    step(0, 0, 0, 0, 0, 0, 1, 0, "mid_wait", o);
    async_reset("mid_wait_reset");
    idle("mw_boot0", o);
    idle("mw_boot1", o);

    // Nine consecutive load-use stalls (saturates a 3-bit counter)
    for (int i = 0; i < 9; i++) step(5, 0, 0, 1, 5, 0, 0, 0, "lu9", o);
    idle("lu9_done", o);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if (err && $urandom_range(0, 2) == 0) async_reset("rnd_reset");
      else if ($urandom_range(0, 99) == 0) async_reset("rnd_reset_any");
      step(REG_W'($urandom_range(0, 3)), REG_W'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           REG_W'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), "rnd", o);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
